// File: rtl/idpair_axis_packer.sv
// rtl/idpair_axis_packer.sv - round-robin multi-lane ID-pair packer onto one AXI-Stream output
module idpair_axis_packer #(
    parameter int N_CH          = 4,
    parameter int VEC_ID_WIDTH  = 16,
    parameter int OUT_BUS_WIDTH = 128,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                           ap_clk,
    input  logic                           ap_rst,
    input  logic [N_CH-1:0]                i_ChMask,
    input  logic [N_CH*2*VEC_ID_WIDTH-1:0] S_AXIS_ID_PAIR_tdata,
    input  logic [N_CH-1:0]                S_AXIS_ID_PAIR_tvalid,
    input  logic [N_CH-1:0]                S_AXIS_ID_PAIR_tlast,
    output logic [N_CH-1:0]                S_AXIS_ID_PAIR_tready,
    output logic [OUT_BUS_WIDTH-1:0]       M_AXIS_ID_PAIR_tdata,
    output logic [OUT_BUS_WIDTH/8-1:0]     M_AXIS_ID_PAIR_tkeep,
    output logic                           M_AXIS_ID_PAIR_tvalid,
    output logic                           M_AXIS_ID_PAIR_tlast,
    input  logic                           M_AXIS_ID_PAIR_tready,
    output logic [CNT_WIDTH-1:0]           o_PairCount,
    output logic                           o_Busy
);

    localparam int PAIR_W = 2 * VEC_ID_WIDTH;
    localparam int PAIR_B = PAIR_W / 8;
    localparam int PPB    = OUT_BUS_WIDTH / PAIR_W;
    localparam int KEEP_W = OUT_BUS_WIDTH / 8;
    localparam int PTR_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int FILL_W = $clog2(PPB + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_LAST  = 2'd3
    } state_t;

    state_t                       state_q, state_d;
    logic [PTR_W-1:0]             ptr_q, ptr_d;
    logic [N_CH-1:0]              done_q, done_d;
    logic [N_CH-1:0]              mask_q, mask_d;
    logic [PPB-1:0][PAIR_W-1:0]   pack_q, pack_d;
    logic [FILL_W-1:0]            fill_q, fill_d;
    logic                         out_valid_q, out_valid_d;
    logic [OUT_BUS_WIDTH-1:0]     out_data_q, out_data_d;
    logic [KEEP_W-1:0]            out_keep_q, out_keep_d;
    logic                         out_last_q, out_last_d;
    logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;

    logic [N_CH-1:0]              mask_eff;
    logic [N_CH-1:0]              eligible;
    logic [N_CH-1:0]              grant_oh;
    logic                         grant_any;
    logic [PTR_W-1:0]             ptr_after;
    logic [PAIR_W-1:0]            pair_data;
    logic                         pair_last;
    logic                         pack_full;
    logic                         out_free;
    logic                         slot_free;
    logic                         accept;

    // Round-robin pick from ptr_q among valid, enabled, not-done lanes; gate by free slot
    always_comb begin
        mask_eff  = (state_q == ST_IDLE) ? i_ChMask : mask_q;
        eligible  = S_AXIS_ID_PAIR_tvalid & ~done_q & mask_eff;
        grant_oh  = '0;
        grant_any = 1'b0;
        ptr_after = ptr_q;
        for (int k = 0; k < N_CH; k++) begin
            for (int c = 0; c < N_CH; c++) begin
                if (!grant_any && eligible[c] && (c == (int'(ptr_q) + k) % N_CH)) begin
                    grant_any   = 1'b1;
                    grant_oh[c] = 1'b1;
                    ptr_after   = PTR_W'((c + 1) % N_CH);
                end
            end
        end
        pair_data = '0;
        pair_last = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            if (grant_oh[c]) begin
                pair_data = S_AXIS_ID_PAIR_tdata[c*PAIR_W +: PAIR_W];
                pair_last = S_AXIS_ID_PAIR_tlast[c];
            end
        end
        pack_full = (fill_q == FILL_W'(PPB));
        out_free  = !out_valid_q || M_AXIS_ID_PAIR_tready;
        slot_free = !pack_full || out_free;
        // reset is folded in so tready reads zero while ap_rst is held
        accept    = !ap_rst && grant_any && slot_free &&
                    ((state_q == ST_IDLE) || (state_q == ST_RUN));
        S_AXIS_ID_PAIR_tready = accept ? grant_oh : '0;
    end

    // Next state: pack/output movement, done tracking, pair counter and frame FSM
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        done_d      = done_q;
        mask_d      = mask_q;
        pack_d      = pack_q;
        fill_d      = fill_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        cnt_d       = cnt_q;

        if (out_valid_q && M_AXIS_ID_PAIR_tready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            ptr_d = ptr_after;
            if (pair_last) begin
                done_d = done_q | grant_oh;
            end
            if (pack_full) begin
                // full pack is held back until now so the final beat can carry tlast
                out_valid_d = 1'b1;
                out_data_d  = pack_q;
                out_keep_d  = '1;
                out_last_d  = 1'b0;
                pack_d[0]   = pair_data;
                fill_d      = FILL_W'(1);
            end else begin
                for (int k = 0; k < PPB; k++) begin
                    if (FILL_W'(k) == fill_q) begin
                        pack_d[k] = pair_data;
                    end
                end
                fill_d = fill_q + FILL_W'(1);
            end
            if (state_q == ST_IDLE) begin
                cnt_d   = CNT_WIDTH'(1);
                mask_d  = i_ChMask;
                state_d = ST_RUN;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end

        case (state_q)
            ST_IDLE: ;
            ST_RUN: begin
                if (&(done_q | ~mask_q)) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (out_free) begin
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b1;
                    for (int k = 0; k < PPB; k++) begin
                        if (FILL_W'(k) < fill_q) begin
                            out_data_d[k*PAIR_W +: PAIR_W] = pack_q[k];
                            out_keep_d[k*PAIR_B +: PAIR_B] = '1;
                        end else begin
                            out_data_d[k*PAIR_W +: PAIR_W] = '1;
                            out_keep_d[k*PAIR_B +: PAIR_B] = '0;
                        end
                    end
                    fill_d  = '0;
                    state_d = ST_LAST;
                end
            end
            ST_LAST: begin
                if (out_valid_q && M_AXIS_ID_PAIR_tready) begin
                    done_d  = '0;
                    state_d = ST_IDLE;
                end
            end
            default: ;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            done_q      <= '0;
            mask_q      <= '0;
            pack_q      <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            done_q      <= done_d;
            mask_q      <= mask_d;
            pack_q      <= pack_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            cnt_q       <= cnt_d;
        end
    end

    assign M_AXIS_ID_PAIR_tdata  = out_data_q;
    assign M_AXIS_ID_PAIR_tkeep  = out_keep_q;
    assign M_AXIS_ID_PAIR_tvalid = out_valid_q;
    assign M_AXIS_ID_PAIR_tlast  = out_last_q;
    assign o_PairCount           = cnt_q;
    assign o_Busy                = (state_q != ST_IDLE);

endmodule
